// File: rtl/dmem_responder_if.sv
// Handshake and status bundle between the MEMORY stage and the data-memory responder.
interface dmem_responder_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        stall;
  logic        misalign_err;
  logic [15:0] rd_count;
  logic [15:0] wr_count;

  modport master (
    output req, we, addr, wdata,
    input  rdata, ready, stall, misalign_err, rd_count, wr_count
  );

  modport slave (
    input  req, we, addr, wdata,
    output rdata, ready, stall, misalign_err, rd_count, wr_count
  );
endinterface

// File: rtl/dmem_responder.sv
// Multi-cycle word data memory with wait states, one-cycle ready pulse, pipeline stall,
// sticky misalignment flag and saturating access counters.
module dmem_responder #(
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  dmem_responder_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t state, state_next;

  logic [31:0]           mem [0:(1 << ADDR_WIDTH) - 1];
  logic                  lat_we;
  logic [ADDR_WIDTH-1:0] lat_idx;
  logic [31:0]           lat_wdata;
  logic [3:0]            wait_cnt;
  logic [31:0]           rdata_q;
  logic                  merr_q;
  logic [15:0]           rd_cnt;
  logic [15:0]           wr_cnt;
  logic                  ready;

  logic                  accept;
  logic                  aligned_in;
  logic                  commit;
  logic                  acc_we;
  logic [ADDR_WIDTH-1:0] acc_idx;
  logic [31:0]           acc_wdata;
  logic                  unused_addr_bits;

  assign accept           = (state == IDLE) && bus.req;
  assign aligned_in       = (bus.addr[1:0] == 2'b00);
  assign unused_addr_bits = ^bus.addr[31:ADDR_WIDTH+2];

  // With zero wait states the access commits on its accepting edge, so the live bus
  // values are used there instead of the latched copies.
  always_comb begin
    acc_we    = lat_we;
    acc_idx   = lat_idx;
    acc_wdata = lat_wdata;
    if (state == IDLE) begin
      acc_we    = bus.we;
      acc_idx   = bus.addr[ADDR_WIDTH+1:2];
      acc_wdata = bus.wdata;
    end
  end

  assign commit = rst && ((accept && aligned_in && (WAIT_CYCLES == 0)) ||
                          ((state == BUSY) && (wait_cnt == '0)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (bus.req) begin
          if (!aligned_in || (WAIT_CYCLES == 0)) state_next = DONE;
          else                                   state_next = BUSY;
        end
      end
      BUSY:    if (wait_cnt == '0) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ready     = (state == DONE);
    bus.stall = bus.req & ~ready;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lat_we    <= 1'b0;
      lat_idx   <= '0;
      lat_wdata <= '0;
      wait_cnt  <= '0;
      rdata_q   <= '0;
      merr_q    <= 1'b0;
      rd_cnt    <= '0;
      wr_cnt    <= '0;
    end else begin
      if (accept) begin
        lat_we    <= bus.we;
        lat_idx   <= bus.addr[ADDR_WIDTH+1:2];
        lat_wdata <= bus.wdata;
        wait_cnt  <= WAIT_INIT;
        if (!aligned_in) begin
          merr_q  <= 1'b1;
          rdata_q <= '0;
        end
      end else if ((state == BUSY) && (wait_cnt != '0)) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
      if (commit) begin
        if (acc_we) begin
          if (wr_cnt != '1) wr_cnt <= wr_cnt + 16'd1;
        end else begin
          rdata_q <= mem[acc_idx];
          if (rd_cnt != '1) rd_cnt <= rd_cnt + 16'd1;
        end
      end
    end
  end

  // Storage is deliberately left out of reset; commit is already gated by rst.
  always_ff @(posedge clk) begin
    if (commit && acc_we) mem[acc_idx] <= acc_wdata;
  end

  assign bus.ready        = ready;
  assign bus.rdata        = rdata_q;
  assign bus.misalign_err = merr_q;
  assign bus.rd_count     = rd_cnt;
  assign bus.wr_count     = wr_cnt;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: one instance with two wait states, one with none.
module tb_dmem_responder;

  typedef struct {
    bit          chk_rd;
    logic [31:0] rdata;
    logic [15:0] rdc;
    logic [15:0] wrc;
    logic        merr;
  } exp_t;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  int   errors = 0;
  int   checks = 0;

  exp_t        q_a[$];
  exp_t        q_b[$];
  logic [15:0] m_rd [2];
  logic [15:0] m_wr [2];
  logic        m_merr [2];

  dmem_responder_if bus_a();
  dmem_responder_if bus_b();

  dmem_responder #(.ADDR_WIDTH(8), .WAIT_CYCLES(2)) dut_a (.clk(clk), .rst(rst_a), .bus(bus_a));
  dmem_responder #(.ADDR_WIDTH(8), .WAIT_CYCLES(0)) dut_b (.clk(clk), .rst(rst_b), .bus(bus_b));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input bit b, input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] d);
    if (b) begin
      bus_b.req = r; bus_b.we = w; bus_b.addr = a; bus_b.wdata = d;
    end else begin
      bus_a.req = r; bus_a.we = w; bus_a.addr = a; bus_a.wdata = d;
    end
  endtask

  function automatic void get_rs(input bit b, output logic r, output logic s);
    r = b ? bus_b.ready : bus_a.ready;
    s = b ? bus_b.stall : bus_a.stall;
  endfunction

  task automatic access(input bit b, input bit w, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] exp_rd, input int exp_lat);
    exp_t e;
    int   cyc;
    logic rdy, stl;
    @(negedge clk);
    e.chk_rd = 1'b1;
    e.rdata  = exp_rd;
    if (a[1:0] != 2'b00) begin
      m_merr[b] = 1'b1;
      e.rdata   = '0;
    end else if (w) begin
      e.chk_rd = 1'b0;
      if (m_wr[b] != 16'hFFFF) m_wr[b] = m_wr[b] + 16'd1;
    end else begin
      if (m_rd[b] != 16'hFFFF) m_rd[b] = m_rd[b] + 16'd1;
    end
    e.rdc  = m_rd[b];
    e.wrc  = m_wr[b];
    e.merr = m_merr[b];
    if (b) q_b.push_back(e);
    else   q_a.push_back(e);
    drive(b, 1'b1, w, a, d);
    #1;
    cyc = 0;
    get_rs(b, rdy, stl);
    while (rdy !== 1'b1 && cyc < 40) begin
      chk("stall_while_waiting", {31'd0, stl}, 32'd1);
      @(negedge clk);
      #1;
      cyc++;
      get_rs(b, rdy, stl);
    end
    chk("latency", cyc, exp_lat);
    chk("stall_in_ready_cycle", {31'd0, stl}, 32'd0);
    drive(b, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic check_resp(input bit b, input logic [31:0] rd, input logic [15:0] rc,
                            input logic [15:0] wc, input logic me);
    exp_t e;
    if ((b && q_b.size() == 0) || (!b && q_a.size() == 0)) begin
      checks++;
      errors++;
      $display("FAIL unexpected_ready: got ready on dut %0d expected no pending access", b);
    end else begin
      e = b ? q_b.pop_front() : q_a.pop_front();
      if (e.chk_rd) chk("rdata", rd, e.rdata);
      chk("rd_count", {16'd0, rc}, {16'd0, e.rdc});
      chk("wr_count", {16'd0, wc}, {16'd0, e.wrc});
      chk("misalign_err", {31'd0, me}, {31'd0, e.merr});
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (bus_a.ready === 1'b1)
      check_resp(1'b0, bus_a.rdata, bus_a.rd_count, bus_a.wr_count, bus_a.misalign_err);
  end

  initial forever begin
    @(negedge clk);
    if (bus_b.ready === 1'b1)
      check_resp(1'b1, bus_b.rdata, bus_b.rd_count, bus_b.wr_count, bus_b.misalign_err);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of test expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_rd[i] = '0; m_wr[i] = '0; m_merr[i] = 1'b0;
    end
    rst_a = 1'b0;
    rst_b = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    #1;
    chk("reset_ready", {31'd0, bus_a.ready}, 32'd0);
    chk("reset_rdata", bus_a.rdata, 32'd0);
    chk("reset_merr", {31'd0, bus_a.misalign_err}, 32'd0);
    chk("reset_counts", {bus_a.rd_count, bus_a.wr_count}, 32'd0);
    chk("reset_stall_low", {31'd0, bus_a.stall}, 32'd0);
    bus_a.req = 1'b1;
    #1;
    chk("reset_stall_follows_req", {31'd0, bus_a.stall}, 32'd1);
    bus_a.req = 1'b0;
    repeat (2) @(negedge clk);
    rst_a = 1'b1;
    rst_b = 1'b1;

    // two wait states: store, aliasing loads, misaligned load
    access(1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'd0, 3);
    access(1'b0, 1'b0, 32'h0000_0010, 32'd0, 32'hDEAD_BEEF, 3);
    access(1'b0, 1'b0, 32'h0000_0410, 32'd0, 32'hDEAD_BEEF, 3);
    access(1'b0, 1'b0, 32'h0000_0013, 32'd0, 32'd0, 1);
    access(1'b0, 1'b1, 32'h0000_0012, 32'hFFFF_FFFF, 32'd0, 1);
    access(1'b0, 1'b0, 32'h0000_0010, 32'd0, 32'hDEAD_BEEF, 3);
    access(1'b0, 1'b1, 32'h0000_0020, 32'h1111_1111, 32'd0, 3);

    // abort an in-flight store with reset
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 32'h0000_0020, 32'h55AA_55AA);
    @(posedge clk);
    #2;
    rst_a = 1'b0;
    #1;
    chk("abort_ready", {31'd0, bus_a.ready}, 32'd0);
    chk("abort_rdata", bus_a.rdata, 32'd0);
    chk("abort_merr", {31'd0, bus_a.misalign_err}, 32'd0);
    chk("abort_counts", {bus_a.rd_count, bus_a.wr_count}, 32'd0);
    chk("abort_stall", {31'd0, bus_a.stall}, 32'd1);
    m_rd[0] = '0; m_wr[0] = '0; m_merr[0] = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_a = 1'b1;
    access(1'b0, 1'b0, 32'h0000_0020, 32'd0, 32'h1111_1111, 3);

    // zero wait states, back-to-back
    access(1'b1, 1'b1, 32'h0000_0000, 32'h0000_0001, 32'd0, 1);
    access(1'b1, 1'b1, 32'h0000_0004, 32'h0000_0002, 32'd0, 1);
    access(1'b1, 1'b0, 32'h0000_0000, 32'd0, 32'h0000_0001, 1);
    access(1'b1, 1'b0, 32'h0000_0004, 32'd0, 32'h0000_0002, 1);

    // store counter saturation
    @(negedge clk);
    force dut_b.wr_cnt = 16'hFFFE;
    #1;
    release dut_b.wr_cnt;
    m_wr[1] = 16'hFFFE;
    access(1'b1, 1'b1, 32'h0000_0008, 32'h0000_00A1, 32'd0, 1);
    access(1'b1, 1'b1, 32'h0000_0008, 32'h0000_00A2, 32'd0, 1);
    access(1'b1, 1'b1, 32'h0000_0008, 32'h0000_00A3, 32'd0, 1);
    access(1'b1, 1'b0, 32'h0000_0008, 32'd0, 32'h0000_00A3, 1);

    repeat (3) @(negedge clk);
    chk("pending_a", q_a.size(), 32'd0);
    chk("pending_b", q_b.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Multi-cycle data-memory responder for the pipelined MIPS core's MEMORY stage. It accepts word load/store requests, inserts a configurable number of wait states, and commits writes or returns read data. It signals completion with a one-cycle `ready` pulse and drives a `stall` the hazard unit uses to freeze the pipeline. Misaligned accesses are flagged and never touch storage.

## Interface
- `ADDR_WIDTH`, 8, word-address bits; storage depth is 2^ADDR_WIDTH 32-bit words.
- `WAIT_CYCLES`, 2, wait states inserted before an aligned access completes; legal range 0–15.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  one clock; reset is asynchronous and active-low.
- `req`  in  1  access request (MEMORY-stage load or store valid); held high by the requester until `ready`.
- `we`  in  1  1 = store, 0 = load; sampled at acceptance.
- `addr`  in  32  byte address (aluoutM); sampled at acceptance.
- `wdata`  in  32  store data (writedataM); sampled at acceptance.
- `rdata`  out  32  load result (readdataM); registered.
- `ready`  out  1  one-cycle completion pulse.
- `stall`  out  1  `req & ~ready`, combinational; feeds the hazard unit to hold F/D/E/M.
- `misalign_err`  out  1  sticky flag: set by any access with addr[1:0] != 0.
- `rd_count`, `wr_count`  out  16 each  saturating counts of completed aligned loads and stores.

## Operation
- Word index = addr[ADDR_WIDTH+1:2]; addr[31:ADDR_WIDTH+2] ignored (aliases).
- FSM states: IDLE, BUSY, DONE.
  - IDLE: on `req`=1, latch we/addr/wdata.
    - Misaligned: go to DONE, set `misalign_err`, load `rdata`=0, no storage write, no counter change.
    - Aligned with WAIT_CYCLES=0: go to DONE.
    - Aligned with WAIT_CYCLES>0: go to BUSY with wait counter = WAIT_CYCLES-1.
  - BUSY: decrement the counter each cycle. On the cycle it is 0, go to DONE.
  - DONE: `ready`=1 for exactly this cycle. `req` is ignored here, since it still belongs to the completing access. Always return to IDLE.
- Commit happens on the edge that enters DONE from an aligned access:
  - store writes `wdata` to the word and increments `wr_count`;
  - load loads `rdata` from the word and increments `rd_count`.
- `rdata` holds its value except on load completion, misaligned completion, or reset.
- A store to word N followed by a load of N returns the new data. Storage has no read/write overlap because only one access is in flight.
- Counters saturate at 16'hFFFF.
- `req` deasserted while in BUSY violates the protocol. The latched access still completes normally.
- `misalign_err` clears only on reset.

## Timing
- Reset (rst=0, immediate, no clock needed):
  - state IDLE; `ready`=0, `rdata`=0, `misalign_err`=0, counters 0;
  - `stall` follows `req`;
  - storage contents are not reset;
  - an in-flight access is aborted with no write.
- Latency, with the accepting edge at cycle 0:
  - aligned access: `ready` high during cycle WAIT_CYCLES+1;
  - misaligned access: `ready` high during cycle 1.
- `stall` is high from `req` assertion through the cycle before `ready`. It is low in the `ready` cycle, so the pipeline advances on that edge.
- Back-to-back: a new `req` in the cycle after DONE is accepted in IDLE. Minimum spacing between completions is WAIT_CYCLES+2 cycles.
- Reset release mid-cycle: the first acceptance happens on the first rising edge with rst=1.

## Test plan
- Reset, then a store with WAIT_CYCLES=2, addr=0x10, wdata=0xDEADBEEF, held until `ready`:
  - `stall`=1 for 3 cycles, then `ready`=1 in cycle 3;
  - `wr_count`=1.
- Load addr=0x10 after that store -> `rdata`=0xDEADBEEF in the `ready` cycle, `rd_count`=1. A load from addr=0x410 (aliases word 4 with ADDR_WIDTH=8) also returns 0xDEADBEEF.
- Load addr=0x13 -> `ready` in cycle 1, `rdata`=0, `misalign_err`=1 and staying 1. Word 4 is unchanged and both counters are unchanged.
- Re-parameterize with WAIT_CYCLES=0 and run back-to-back stores to 0x0 (0x1) and 0x4 (0x2), then loads:
  - each access takes 2 cycles with 1 `ready` pulse;
  - loads return 0x1 and 0x2.
- Assert rst=0 while BUSY on a store to 0x20 (0x55AA55AA):
  - outputs go to reset values immediately;
  - a later load of 0x20 does not return 0x55AA55AA (the word holds its prior value).
- Preload `wr_count`=16'hFFFE (run 65534 stores, or force), then do 3 stores -> `wr_count`=16'hFFFF and holds.
